serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor, the inverse companion of the team's serial adder. It captures two WIDTH-bit operands on a start strobe and computes a - b LSB-first, one bit per clock, through a single full-subtractor and a borrow flop. It returns a WIDTH+1-bit two's-complement difference with a done pulse. It sits beside the serial adder in the Spartan-7 arithmetic demo datapath.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request side and the slave returns the registered result.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor plus a borrow flop, LSB first.
// Produces a WIDTH+1-bit two's-complement difference WIDTH cycles after an accepted start.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]    diff_q, diff_d;
  logic              borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;
  logic              a0, b0, d, br_next;

  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign d       = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        // Result bits enter at the MSB so the LSB-first stream lands in place.
        res_d = {d, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d   = {br_next, d, res_q[WIDTH-1:1]};
          borrow_d = br_next;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Expected differences are queued when a start is driven and popped on done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  logic [4:0] exp4_q[$];
  logic [8:0] exp8_q[$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input string name);
    int lat;
    int busy_cnt;
    logic [4:0] exp;
    @(negedge clk);
    bus4.a = a;
    bus4.b = b;
    bus4.start = 1'b1;
    exp4_q.push_back({1'b0, a} - {1'b0, b});
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    lat = 0;
    busy_cnt = (bus4.busy === 1'b1) ? 1 : 0;
    while (bus4.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus4.busy === 1'b1) busy_cnt++;
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    total++;
    if (busy_cnt != 4) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d want 4", name, busy_cnt);
    end
    if (exp4_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: empty queue", name);
    end else begin
      exp = exp4_q.pop_front();
      total++;
      if (bus4.diff !== exp) begin
        bad++;
        $display("FAIL %s diff: got %b want %b", name, bus4.diff, exp);
      end
      total++;
      if (bus4.borrow !== exp[4]) begin
        bad++;
        $display("FAIL %s borrow: got %b want %b", name, bus4.borrow, exp[4]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (bus4.done !== 1'b0) begin
      bad++;
      $display("FAIL %s done width: got %b want 0", name, bus4.done);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input string name);
    int lat;
    logic [8:0] exp;
    @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    exp8_q.push_back({1'b0, a} - {1'b0, b});
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    if (exp8_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: empty queue", name);
    end else begin
      exp = exp8_q.pop_front();
      total++;
      if (bus8.diff !== exp) begin
        bad++;
        $display("FAIL %s diff: got %h want %h", name, bus8.diff, exp);
      end
      total++;
      if (bus8.borrow !== exp[8]) begin
        bad++;
        $display("FAIL %s borrow: got %b want %b", name, bus8.borrow, exp[8]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #50;
    total++;
    if ({bus4.busy, bus4.done, bus4.borrow, bus4.diff} !== 8'd0) begin
      bad++;
      $display("FAIL reset_w4: got busy=%b done=%b borrow=%b diff=%b want all 0",
               bus4.busy, bus4.done, bus4.borrow, bus4.diff);
    end
    total++;
    if ({bus8.busy, bus8.done, bus8.borrow, bus8.diff} !== 12'd0) begin
      bad++;
      $display("FAIL reset_w8: got busy=%b done=%b borrow=%b diff=%h want all 0",
               bus8.busy, bus8.done, bus8.borrow, bus8.diff);
    end
    #50;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_release: got busy=%b done=%b want 0 0", bus4.busy, bus4.done);
    end
  endtask

  task automatic test_subtract();
    op4(4'b1011, 4'b0110, "pos_11_6");
    op4(4'b0110, 4'b1011, "neg_6_11");
    op4(4'b0000, 4'b1111, "neg_0_15");
    op4(4'b1111, 4'b0001, "pos_15_1");
    op4(4'b1010, 4'b1010, "equal_10");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int last_acc;
    int n_acc;
    int n_done;
    logic prev_busy;
    logic prev_done;
    logic [4:0] exp;
    @(negedge clk);
    bus4.a = 4'd3;
    bus4.b = 4'd9;
    bus4.start = 1'b1;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    last_acc = -1;
    n_acc = 0;
    n_done = 0;
    cyc = 0;
    while (n_done < 3 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus4.busy === 1'b1 && prev_busy === 1'b0) begin
        exp4_q.push_back(5'd3 - 5'd9);
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 6) begin
            bad++;
            $display("FAIL b2b accept interval: got %0d want 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      if (bus4.done === 1'b1) begin
        n_done++;
        total++;
        if (prev_done === 1'b1) begin
          bad++;
          $display("FAIL b2b done width: got >=2 cycles want 1");
        end
        if (exp4_q.size() != 0) begin
          exp = exp4_q.pop_front();
          total++;
          if (bus4.diff !== exp) begin
            bad++;
            $display("FAIL b2b diff: got %b want %b", bus4.diff, exp);
          end
        end
      end
      prev_busy = bus4.busy;
      prev_done = bus4.done;
    end
    bus4.start = 1'b0;
    total++;
    if (n_done != 3 || n_acc != 3) begin
      bad++;
      $display("FAIL b2b counts: got acc=%0d done=%0d want 3 3", n_acc, n_done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int n_done;
    logic [4:0] got;
    logic [4:0] exp;
    @(negedge clk);
    bus4.a = 4'b1011;
    bus4.b = 4'b0110;
    bus4.start = 1'b1;
    exp4_q.push_back(5'd11 - 5'd6);
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus4.a = 4'b0000;
    bus4.b = 4'b1111;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    n_done = 0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus4.done === 1'b1) begin
        n_done++;
        got = bus4.diff;
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL ignore done count: got %0d want 1", n_done);
    end
    exp = exp4_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ignore diff: got %b want %b", got, exp);
    end
    total++;
    if (bus4.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore queued start: got busy=%b want 0", bus4.busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n_done;
    @(negedge clk);
    bus4.a = 4'b1011;
    bus4.b = 4'b0110;
    bus4.start = 1'b1;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({bus4.busy, bus4.done, bus4.borrow, bus4.diff} !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b borrow=%b diff=%b want all 0",
               bus4.busy, bus4.done, bus4.borrow, bus4.diff);
    end
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus4.done === 1'b1) n_done++;
    end
    total++;
    if (n_done != 0) begin
      bad++;
      $display("FAIL aborted done: got %0d pulses want 0", n_done);
    end
    op4(4'b0101, 4'b0011, "after_reset");
  endtask

  task automatic test_width8();
    op8(8'h00, 8'h01, "w8_0_1");
    op8(8'hC8, 8'h64, "w8_c8_64");
    op8(8'h37, 8'hF0, "w8_37_f0");
  endtask

  initial begin
    reset = 1'b0;
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    test_reset();
    test_subtract();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_shift();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
